alu_cmd_responder: RTL
======================

// Module: alu_cmd_responder
// PURPOSE
//  Responder (ALU-side) end of the Req/Ack command handshake issued by the command sequencer.
//  Latches Cmd/Op1/Op2/Cin on an accepted request and executes add, sub, multi-cycle multiply or multi-cycle divide.
//  Presents the result on Alu_Out and raises Ack; four-phase handshake.
//  Sits between the command sequencer (initiator) and the result consumer.
// PARAMETERS
//  N  8  operand width; Alu_Out is 2*N bits; N >= 2
// PORTS
//  Clk      in   1    single clock, all state changes on posedge
//  Rst      in   1    asynchronous, active-low reset
//  Req      in   1    request from initiator; four-phase
//  Cmd      in   2    00 add, 01 sub, 10 mul, 11 div
//  Cin      in   1    carry-in (add) / borrow-in (sub); ignored for mul/div
//  Op1      in   N    operand 1 (unsigned)
//  Op2      in   N    operand 2 (unsigned)
//  Alu_Out  out  2N   registered result
//  Ack      out  1    result valid / request acknowledged
//  Busy     out  1    1 while in EXEC or DONE
//  Div_Err  out  1    1 if the last completed op was a divide by zero
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE, Ack=0, Busy=0, Alu_Out=0, Div_Err=0, cycle counter=0.
//   Takes effect immediately; aborts any op in flight without producing a result.
//  FSM states: IDLE -> EXEC -> DONE -> IDLE.
//  IDLE:
//   - Req=1 at posedge k: latch Cmd, Op1, Op2, Cin into internal registers.
//   - Load counter with L (L=1 for add/sub, L=N for mul/div); go to EXEC; Busy=1.
//  EXEC:
//   - One step per edge; uses only the latched values.
//   - Input changes and Req deassertion during EXEC are ignored.
//   - On the L-th EXEC edge (edge k+L): write Alu_Out, update Div_Err, Ack=1, go to DONE.
//   - Latency: Ack rises after edge k+L (add/sub k+1, mul/div k+N).
//  DONE:
//   - Ack=1 and Alu_Out held while Req=1.
//   - First edge sampling Req=0: Ack=0, Busy=0, go to IDLE.
//   - If Req was already 0 on completion, Ack is high for exactly one cycle.
//   - A new request is accepted only from IDLE, so Req must go low between transactions.
//  Alu_Out holds its value across IDLE until the next completion overwrites it.
//  Arithmetic (all unsigned):
//   - add: Alu_Out = zero-extend({carry, Op1+Op2+Cin}) (N+1 bits).
//   - sub: Alu_Out[N-1:0] = Op1-Op2-Cin mod 2^N; Alu_Out[N] = borrow (1 iff Op1 < Op2+Cin); upper bits 0.
//   - mul: shift-add, one partial product per cycle; Alu_Out = Op1*Op2 (full 2N bits).
//   - div: restoring division, one quotient bit per cycle; Alu_Out = {remainder[N-1:0], quotient[N-1:0]}.
//  Divide by zero (latched Op2==0, Cmd=11):
//   - Completes with L=1; Alu_Out = {Op1, {N{1'b1}}}; Div_Err=1.
//   - Div_Err is cleared on every other completion.
//  Reset released mid-sequence: the block returns to IDLE; a Req already high is accepted at the first edge after release.
// TESTING (N=8)
//  1. add 0xFF+0x01, Cin=1 -> Alu_Out=0x0101, Ack one edge after acceptance, Div_Err=0.
//  2. sub 0x05-0x07, Cin=0 -> Alu_Out=0x01FE (bit8 borrow); then 0x07-0x05, Cin=1 -> 0x0001.
//  3. mul 0xFF*0xFF -> Alu_Out=0xFE01 after 8 EXEC edges; Ack stays 1 while Req=1 and falls one edge after Req drops.
//  4. div 200/7 -> Alu_Out=0x041C after 8 edges; div 0x2A/0x00 -> Alu_Out=0x2AFF, Div_Err=1, latency 1; next add clears Div_Err.
//  5. Assert Rst on the 4th EXEC edge of 0x12*0x34 -> Ack=0, Busy=0, Alu_Out=0 immediately; after release, add 0x10+0x20 -> 0x0030.
//  6. Drop Req and change Op1/Op2 during mul 0x0F*0x03 -> Alu_Out=0x002D, Ack high exactly one cycle; Req held high with no low phase -> no second transaction.

Source files
------------

// File: rtl/alu_cmd_responder.sv
// ALU responder for the four-phase Req/Ack command handshake.
// Add/sub in one step; multiply and divide run N shift steps.
module alu_cmd_responder #(
  parameter int N = 8
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Req,
  input  logic [1:0]     Cmd,
  input  logic           Cin,
  input  logic [N-1:0]   Op1,
  input  logic [N-1:0]   Op2,
  output logic [2*N-1:0] Alu_Out,
  output logic           Ack,
  output logic           Busy,
  output logic           Div_Err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [1:0]     cmd_q;
  logic           cin_q;
  logic [N-1:0]   op1_q;
  logic [N-1:0]   op2_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_ld;

  logic           is_add;
  logic           is_sub;
  logic           is_mul;
  logic           is_div;
  logic           last;
  logic           div_zero;
  logic [N-1:0]   hi_nxt;
  logic [N-1:0]   lo_nxt;
  logic [N:0]     mul_sum;
  logic [N:0]     div_trial;
  logic [N:0]     addsub;
  logic [2*N-1:0] result;

  assign is_add   = (cmd_q == 2'b00);
  assign is_sub   = (cmd_q == 2'b01);
  assign is_mul   = (cmd_q == 2'b10);
  assign is_div   = (cmd_q == 2'b11);
  assign last     = (cnt_q == CW'(1));
  assign div_zero = is_div && (op2_q == '0);

  // A divide by zero finishes in a single step
  assign cnt_ld = (Cmd[1] && !(Cmd[0] && (Op2 == '0)))
                ? CW'(N) : CW'(1);

  assign Ack  = (state == DONE);
  assign Busy = (state != IDLE);

  // One arithmetic step on the latched operands, plus final result
  always_comb begin
    mul_sum   = {1'b0, hi_q}
              + (lo_q[0] ? {1'b0, op1_q} : '0);
    div_trial = {hi_q, lo_q[N-1]} - {1'b0, op2_q};
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    addsub    = '0;
    result    = '0;
    unique case (1'b1)
      is_add: begin
        addsub = {1'b0, op1_q} + {1'b0, op2_q}
               + {{N{1'b0}}, cin_q};
        result = {{(N-1){1'b0}}, addsub};
      end
      is_sub: begin
        addsub = {1'b0, op1_q} - {1'b0, op2_q}
               - {{N{1'b0}}, cin_q};
        result = {{(N-1){1'b0}}, addsub};
      end
      is_mul: begin
        hi_nxt = mul_sum[N:1];
        lo_nxt = {mul_sum[0], lo_q[N-1:1]};
        result = {hi_nxt, lo_nxt};
      end
      is_div: begin
        if (!div_trial[N])
          hi_nxt = div_trial[N-1:0];
        else
          hi_nxt = {hi_q[N-2:0], lo_q[N-1]};
        lo_nxt = {lo_q[N-2:0], ~div_trial[N]};
        result = div_zero ? {op1_q, {N{1'b1}}}
                          : {hi_nxt, lo_nxt};
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: accept in IDLE, finish on last step, wait for Req low
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Req) state_nxt = EXEC;
      EXEC: if (last) state_nxt = DONE;
      DONE: if (!Req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, step registers and result/error outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cmd_q   <= '0;
      cin_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      Alu_Out <= '0;
      Div_Err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req) begin
            cmd_q <= Cmd;
            cin_q <= Cin;
            op1_q <= Op1;
            op2_q <= Op2;
            hi_q  <= '0;
            lo_q  <= (Cmd == 2'b10) ? Op2 : Op1;
            cnt_q <= cnt_ld;
          end
        end
        EXEC: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            Alu_Out <= result;
            Div_Err <= div_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
